// File: rtl/div_stall_unit_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider:
// operands and request in one direction, stall/ready/result back.
interface div_stall_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic                 annul;
    logic                 stallreq_for_ex;
    logic                 ready;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  stallreq_for_ex, ready, result
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output stallreq_for_ex, ready, result
    );
endinterface

// File: rtl/div_stall_unit.sv
// Radix-2 restoring divider for DIV/DIVU in EX; stalls IF..EX while busy and
// returns {remainder, quotient} with a one-cycle ready pulse.
module div_stall_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    div_stall_unit_if.slave      bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DIVZERO, DONE} state_t;

    state_t             state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   divisor_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic               ready_reg;
    logic [2*WIDTH-1:0] result_reg;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     shifted;
    logic [WIDTH-1:0]   sub;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   rem_final;
    logic [WIDTH-1:0]   quo_final;

    // Signed operands are reduced to magnitudes; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    always_comb begin
        mag1 = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
        mag2 = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;
    end

    // One restoring step: bring in the next dividend bit and subtract if it fits.
    // The partial remainder stays below the divisor, so the low WIDTH bits of
    // the difference are exact whenever the subtraction is taken.
    always_comb begin
        shifted = {rem_reg, quo_reg[WIDTH-1]};
        sub     = shifted[WIDTH-1:0] - divisor_reg;
        if (shifted >= {1'b0, divisor_reg}) begin
            rem_next = sub;
            quo_next = {quo_reg[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo_reg[WIDTH-2:0], 1'b0};
        end
        rem_final = neg_r_reg ? -rem_next : rem_next;
        quo_final = neg_q_reg ? -quo_next : quo_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            ready_reg   <= 1'b0;
            result_reg  <= '0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start && !bus.annul) begin
                        divisor_reg <= mag2;
                        quo_reg     <= mag1;
                        rem_reg     <= '0;
                        cnt_reg     <= '0;
                        neg_q_reg   <= bus.signed_div &&
                                       (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                        neg_r_reg   <= bus.signed_div && bus.opdata1[WIDTH-1];
                        state_reg   <= (bus.opdata2 == '0) ? DIVZERO : CALC;
                    end
                end
                CALC: begin
                    if (bus.annul) begin
                        state_reg <= IDLE;
                    end else begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CNT_LAST) begin
                            state_reg  <= DONE;
                            ready_reg  <= 1'b1;
                            result_reg <= {rem_final, quo_final};
                        end
                    end
                end
                DIVZERO: begin
                    if (bus.annul) begin
                        state_reg <= IDLE;
                    end else begin
                        state_reg  <= DONE;
                        ready_reg  <= 1'b1;
                        result_reg <= '0;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // A flush drops the stall in the same cycle so the pipeline can redirect.
    assign bus.stallreq_for_ex = !bus.annul &&
                                 (((state_reg == IDLE) && bus.start) ||
                                  (state_reg == CALC) || (state_reg == DIVZERO));
    assign bus.ready  = ready_reg;
    assign bus.result = result_reg;

endmodule

// File: tb/tb_div_stall_unit.sv
// Directed bench for div_stall_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, annul/reset abort and back-to-back issue.
module tb_div_stall_unit;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    div_stall_unit_if #(.WIDTH(32)) bus ();

    div_stall_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide and wait for ready; lat is the cycle index of ready or -1.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat);
        bus.signed_div = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.start      = 1'b1;
        lat = -1;
        res = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                res = bus.result;
                lat = c;
                bus.start = 1'b0;
            end
            step();
            if (lat >= 0) break;
        end
        bus.start = 1'b0;
        $display("div signed=%0b %h / %h -> result=%h latency=%0d", sgn, a, b, res, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0;
        bus.opdata1 = '0; bus.opdata2 = '0;
        step(); step(); step();
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus.ready); else passes++;
        checks++;
        if (bus.result !== 64'd0) $display("FAIL reset_result got=%h exp=0", bus.result); else passes++;
        checks++;
        if (bus.stallreq_for_ex !== 1'b0) $display("FAIL reset_stall got=%b exp=0", bus.stallreq_for_ex); else passes++;
        rst = 1'b0;
        step();
        $display("reset done");
    endtask

    task automatic test_divu_latency();
        bus.signed_div = 1'b0; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7; bus.start = 1'b1;
        for (int c = 0; c <= 34; c++) begin
            if (c == 33) bus.start = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.stallreq_for_ex !== (c <= 32))
                $display("FAIL divu_stall c%0d got=%b exp=%b", c, bus.stallreq_for_ex, (c <= 32));
            else passes++;
            checks++;
            if (bus.ready !== (c == 33))
                $display("FAIL divu_ready c%0d got=%b exp=%b", c, bus.ready, (c == 33));
            else passes++;
            if (c == 33) begin
                checks++;
                if (bus.result !== {32'd2, 32'd14})
                    $display("FAIL divu_100_7 got=%h exp=%h", bus.result, {32'd2, 32'd14});
                else passes++;
            end
            step();
        end
        $display("divu 100/7 latency sequence done");
    endtask

    task automatic test_signed();
        logic [63:0] r;
        int lat;
        do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, r, lat);
        checks++;
        if (r !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) $display("FAIL div_m7_2 got=%h exp=ffffffff_fffffffd", r); else passes++;
        checks++;
        if (lat !== 33) $display("FAIL div_m7_2_lat got=%0d exp=33", lat); else passes++;
        do_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, r, lat);
        checks++;
        if (r !== {32'h0000_0001, 32'hFFFF_FFFD}) $display("FAIL div_7_m2 got=%h exp=00000001_fffffffd", r); else passes++;
    endtask

    task automatic test_divzero();
        bus.signed_div = 1'b0; bus.opdata1 = 32'd5; bus.opdata2 = 32'd0; bus.start = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            if (c == 2) bus.start = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.stallreq_for_ex !== (c <= 1))
                $display("FAIL dz_stall c%0d got=%b exp=%b", c, bus.stallreq_for_ex, (c <= 1));
            else passes++;
            checks++;
            if (bus.ready !== (c == 2))
                $display("FAIL dz_ready c%0d got=%b exp=%b", c, bus.ready, (c == 2));
            else passes++;
            if (c == 2) begin
                checks++;
                if (bus.result !== 64'd0) $display("FAIL dz_result got=%h exp=0", bus.result); else passes++;
            end
            step();
        end
        $display("div 5/0 done");
    endtask

    task automatic test_overflow();
        logic [63:0] r;
        int lat;
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        checks++;
        if (r !== {32'h0000_0000, 32'h8000_0000}) $display("FAIL div_ovf got=%h exp=00000000_80000000", r); else passes++;
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        checks++;
        if (r !== {32'h8000_0000, 32'h0000_0000}) $display("FAIL divu_ovf got=%h exp=80000000_00000000", r); else passes++;
    endtask

    task automatic test_annul();
        logic [63:0] r;
        int lat;
        int seen_ready;
        int seen_stall;
        do_div(1'b0, 32'd100, 32'd7, r, lat);
        // annul in IDLE blocks acceptance
        bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3; bus.start = 1'b1; bus.annul = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stallreq_for_ex !== 1'b0) $display("FAIL idle_annul_stall got=%b exp=0", bus.stallreq_for_ex); else passes++;
        step();
        bus.start = 1'b0; bus.annul = 1'b0;
        seen_ready = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.ready === 1'b1 || bus.stallreq_for_ex === 1'b1) seen_ready++;
            step();
        end
        checks++;
        if (seen_ready != 0) $display("FAIL idle_annul_accepted got=%0d exp=0", seen_ready); else passes++;
        // annul mid-CALC
        bus.start = 1'b1;
        for (int c = 0; c < 10; c++) step();
        bus.annul = 1'b1; bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.stallreq_for_ex !== 1'b0) $display("FAIL calc_annul_stall got=%b exp=0", bus.stallreq_for_ex); else passes++;
        step();
        bus.annul = 1'b0;
        seen_ready = 0;
        seen_stall = 0;
        for (int c = 11; c <= 45; c++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) seen_ready++;
            if (bus.stallreq_for_ex === 1'b1) seen_stall++;
            step();
        end
        checks++;
        if (seen_ready != 0) $display("FAIL annul_ready_pulses got=%0d exp=0", seen_ready); else passes++;
        checks++;
        if (seen_stall != 0) $display("FAIL annul_stall_cycles got=%0d exp=0", seen_stall); else passes++;
        checks++;
        if (bus.result !== {32'd2, 32'd14}) $display("FAIL annul_result_kept got=%h exp=%h", bus.result, {32'd2, 32'd14}); else passes++;
        $display("annul at c10 done");
        do_div(1'b0, 32'd9, 32'd4, r, lat);
        checks++;
        if (r !== {32'd1, 32'd2} || lat !== 33)
            $display("FAIL after_annul got=%h lat=%0d exp=%h lat=33", r, lat, {32'd1, 32'd2});
        else passes++;
    endtask

    task automatic test_reset_abort();
        int seen_ready;
        bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3; bus.start = 1'b1;
        for (int c = 0; c < 10; c++) step();
        rst = 1'b1; bus.start = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.result !== 64'd0) $display("FAIL rst_abort_result got=%h exp=0", bus.result); else passes++;
        checks++;
        if (bus.ready !== 1'b0) $display("FAIL rst_abort_ready got=%b exp=0", bus.ready); else passes++;
        checks++;
        if (bus.stallreq_for_ex !== 1'b0) $display("FAIL rst_abort_stall got=%b exp=0", bus.stallreq_for_ex); else passes++;
        seen_ready = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            @(negedge clk);
            if (bus.ready === 1'b1) seen_ready++;
        end
        step();
        checks++;
        if (seen_ready != 0) $display("FAIL rst_abort_ready_pulses got=%0d exp=0", seen_ready); else passes++;
        $display("reset at c10 done");
    endtask

    task automatic test_back_to_back();
        logic exp_edge;
        bus.signed_div = 1'b0; bus.opdata1 = 32'd20; bus.opdata2 = 32'd3; bus.start = 1'b1;
        for (int c = 0; c <= 68; c++) begin
            if (c == 34) begin
                bus.opdata1 = 32'd9; bus.opdata2 = 32'd4;
            end
            if (c == 68) bus.start = 1'b0;
            exp_edge = (c == 33) || (c == 67);
            @(negedge clk);
            if (c <= 67) begin
                checks++;
                if (bus.stallreq_for_ex !== !exp_edge)
                    $display("FAIL b2b_stall c%0d got=%b exp=%b", c, bus.stallreq_for_ex, !exp_edge);
                else passes++;
            end
            checks++;
            if (bus.ready !== exp_edge)
                $display("FAIL b2b_ready c%0d got=%b exp=%b", c, bus.ready, exp_edge);
            else passes++;
            if (c == 33) begin
                checks++;
                if (bus.result !== {32'd2, 32'd6}) $display("FAIL b2b_first got=%h exp=%h", bus.result, {32'd2, 32'd6}); else passes++;
            end
            if (c == 67) begin
                checks++;
                if (bus.result !== {32'd1, 32'd2}) $display("FAIL b2b_second got=%h exp=%h", bus.result, {32'd1, 32'd2}); else passes++;
            end
            step();
        end
        $display("back-to-back 20/3 then 9/4 done");
    endtask

    initial begin
        test_reset();
        test_divu_latency();
        test_signed();
        test_divzero();
        test_overflow();
        test_annul();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
